// File: rtl/lieat_ifu_pcgen_pkg.sv
// rtl/lieat_ifu_pcgen_pkg.sv - shared widths, FSM encodings and BHT counter helpers for the PC generator
// Defines `XLEN (PC width) and `BPU_IDX (BHT index width) when not already set.
// Optional feature macro used by this slice: LIEAT_BHT_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BPU_IDX
`define BPU_IDX 4
`endif

package lieat_ifu_pcgen_pkg;

    typedef enum logic {
        PCGEN_RUN  = 1'b0,
        PCGEN_HOLD = 1'b1
    } pcgen_state_e;

    localparam logic [`XLEN-1:0] PCGEN_RESET_PC = 32'h8000_0000;
    localparam logic [`XLEN-1:0] PCGEN_PC_STEP  = 4;

    localparam int              BHT_CNT_W    = 2;
    localparam logic [1:0]      BHT_CNT_MAX  = 2'd3;
    localparam logic [1:0]      BHT_CNT_MIN  = 2'd0;
    localparam logic [1:0]      BHT_INIT_DEF = 2'b01;
    localparam int              BHT_ENTRIES  = 1 << `BPU_IDX;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [BHT_CNT_W-1:0] bht_cnt_next(input logic [BHT_CNT_W-1:0] cnt,
                                                          input logic taken);
        if (taken)
            return (cnt == BHT_CNT_MAX) ? cnt : cnt + 2'd1;
        else
            return (cnt == BHT_CNT_MIN) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/lieat_general_dfflr.sv
// rtl/lieat_general_dfflr.sv - load-enabled flop with synchronous active-high reset
// Ports: clock, reset (sync, active-high), lden (load enable), dnxt (next value), qout (state).
module lieat_general_dfflr #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clock) begin
        if (reset)
            qout <= RST_VAL;
        else if (lden)
            qout <= dnxt;
    end

endmodule

// File: rtl/lieat_ifu_bht.sv
// rtl/lieat_ifu_bht.sv - branch history table of 2-bit saturating counters
// Ports: clock, reset; update port prdt_en/prdt_index/prdt_res; read port rd_index -> rd_taken
// (counter MSB). Reads see the current state only; same-cycle writes appear next cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BPU_IDX
`define BPU_IDX 4
`endif
module lieat_ifu_bht
    import lieat_ifu_pcgen_pkg::*;
#(
    parameter logic [1:0] BHT_INIT = BHT_INIT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                prdt_en,
    input  logic [`BPU_IDX-1:0] prdt_index,
    input  logic                prdt_res,
    input  logic [`BPU_IDX-1:0] rd_index,
    output logic                rd_taken
);

    logic [BHT_CNT_W-1:0] cnt [BHT_ENTRIES];

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_cnt
        logic                 wr_hit;
        logic [BHT_CNT_W-1:0] cnt_nxt;

        assign wr_hit  = prdt_en & (prdt_index == i[`BPU_IDX-1:0]);
        assign cnt_nxt = bht_cnt_next(cnt[i], prdt_res);

        lieat_general_dfflr #(.DW(BHT_CNT_W), .RST_VAL(BHT_INIT)) u_cnt (
            .clock (clock),
            .reset (reset),
            .lden  (wr_hit),
            .dnxt  (cnt_nxt),
            .qout  (cnt[i])
        );
    end

    assign rd_taken = cnt[rd_index][BHT_CNT_W-1];

endmodule

// File: rtl/lieat_ifu_pcgen.sv
// rtl/lieat_ifu_pcgen.sv - fetch PC generator with flush/decode redirect, fetch hold and BHT
// Ports: clock, reset (sync, active-high); pc_o_valid/pc_o_ready/pc_o_addr fetch PC handshake;
// dec_redirect_valid/pc decode redirect; flush_req/flush_pc/flush_sh commit flush;
// if_hold_req/if_hold_pc/if_hold_rsp CSR fetch hold; prdt_en/prdt_index/prdt_res BHT update;
// bht_rd_index/bht_rd_taken BHT lookup.
// Macro LIEAT_BHT_EN: defined -> BHT counters present; undefined -> static not-taken.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BPU_IDX
`define BPU_IDX 4
`endif
module lieat_ifu_pcgen
    import lieat_ifu_pcgen_pkg::*;
#(
    parameter logic [`XLEN-1:0] RESET_PC = PCGEN_RESET_PC,
    parameter logic [1:0]       BHT_INIT = BHT_INIT_DEF
) (
    input  logic                clock,
    input  logic                reset,
    output logic                pc_o_valid,
    input  logic                pc_o_ready,
    output logic [`XLEN-1:0]    pc_o_addr,
    input  logic                dec_redirect_valid,
    input  logic [`XLEN-1:0]    dec_redirect_pc,
    input  logic                flush_req,
    input  logic [`XLEN-1:0]    flush_pc,
    output logic                flush_sh,
    input  logic                if_hold_req,
    output logic [`XLEN-1:0]    if_hold_pc,
    output logic                if_hold_rsp,
    input  logic                prdt_en,
    input  logic [`BPU_IDX-1:0] prdt_index,
    input  logic                prdt_res,
    input  logic [`BPU_IDX-1:0] bht_rd_index,
    output logic                bht_rd_taken
);

    logic             state_q;
    pcgen_state_e     state_r;
    pcgen_state_e     state_nxt;
    logic [`XLEN-1:0] pc_r;
    logic [`XLEN-1:0] pc_nxt;
    logic             in_run;
    logic             fire;

    assign state_r = pcgen_state_e'(state_q);
    assign in_run  = (state_r == PCGEN_RUN);

    // Outputs are held low while reset is asserted.
    assign flush_sh    = flush_req & ~reset;
    assign pc_o_valid  = in_run & ~flush_req & ~reset;
    assign fire        = pc_o_valid & pc_o_ready;
    assign if_hold_rsp = (state_r == PCGEN_HOLD) & ~reset;
    assign pc_o_addr   = pc_r;
    assign if_hold_pc  = pc_r;

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            PCGEN_RUN: begin
                // A fire defers the hold by a cycle so if_hold_pc shows the incremented PC.
                if (if_hold_req & ~flush_req & ~fire)
                    state_nxt = PCGEN_HOLD;
            end
            PCGEN_HOLD: begin
                if (flush_req | ~if_hold_req)
                    state_nxt = PCGEN_RUN;
            end
            default: state_nxt = PCGEN_RUN;
        endcase
    end

    always_comb begin
        pc_nxt = pc_r;
        if (flush_req)
            pc_nxt = flush_pc;
        else if (in_run & dec_redirect_valid)
            pc_nxt = dec_redirect_pc;
        else if (fire)
            pc_nxt = pc_r + PCGEN_PC_STEP;
    end

    lieat_general_dfflr #(.DW(1), .RST_VAL(PCGEN_RUN)) u_state (
        .clock (clock),
        .reset (reset),
        .lden  (1'b1),
        .dnxt  (state_nxt),
        .qout  (state_q)
    );

    lieat_general_dfflr #(.DW(`XLEN), .RST_VAL(RESET_PC)) u_pc (
        .clock (clock),
        .reset (reset),
        .lden  (1'b1),
        .dnxt  (pc_nxt),
        .qout  (pc_r)
    );

`ifdef LIEAT_BHT_EN
    lieat_ifu_bht #(.BHT_INIT(BHT_INIT)) u_bht (
        .clock      (clock),
        .reset      (reset),
        .prdt_en    (prdt_en),
        .prdt_index (prdt_index),
        .prdt_res   (prdt_res),
        .rd_index   (bht_rd_index),
        .rd_taken   (bht_rd_taken)
    );
`else
    logic unused_bht;
    assign unused_bht   = ^{prdt_en, prdt_index, prdt_res, bht_rd_index, BHT_INIT};
    assign bht_rd_taken = 1'b0;
`endif

endmodule

// File: doc/lieat_ifu_pcgen.md
Name: lieat_ifu_pcgen

Overview:
Fetch-side PC generator and the far end of the commit stage's redirect/predict interfaces.
- Issues sequential fetch PCs to the IFU over a valid/ready handshake.
- Accepts commit-stage flush redirects (flush_req/flush_pc, acknowledged by flush_sh) and CSR interrupt-hold requests (if_hold_req, answered by if_hold_pc/if_hold_rsp).
- Owns the branch history table written by commit (prdt_en/prdt_index/prdt_res) and read by decode.

Parameters:
RESET_PC, 32'h8000_0000, first fetch PC after reset
BHT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken)

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
pc_o_valid  output  1  fetch PC valid
pc_o_ready  input  1  IFU accepts PC
pc_o_addr  output  `XLEN  fetch PC
dec_redirect_valid  input  1  decode predicted-taken redirect
dec_redirect_pc  input  `XLEN  decode redirect target
flush_req  input  1  commit flush request (held until flush_sh)
flush_pc  input  `XLEN  commit flush target
flush_sh  output  1  flush accepted
if_hold_req  input  1  CSR requests fetch hold (level)
if_hold_pc  output  `XLEN  next PC that would be fetched
if_hold_rsp  output  1  fetch is held, if_hold_pc stable
prdt_en  input  1  BHT update strobe
prdt_index  input  `BPU_IDX  BHT update index
prdt_res  input  1  resolved outcome, 1 = taken
bht_rd_index  input  `BPU_IDX  decode lookup index
bht_rd_taken  output  1  prediction for bht_rd_index (counter MSB)

Interface decision: one clock; reset is synchronous and active-high (ports clock, reset).

Behaviour:
- Register pc_r holds the next PC to fetch. pc_o_addr = pc_r.
- States: RUN, HOLD. Reset: state = RUN, pc_r = RESET_PC, BHT = BHT_INIT, all outputs 0 except pc_o_addr and if_hold_pc, which show RESET_PC.
- RUN:
  - pc_o_valid = ~flush_req.
  - Fire = pc_o_valid & pc_o_ready. On fire, pc_r <= pc_r + 4 (wraps modulo 2^XLEN).
- Redirect priority when updating pc_r: flush_req > dec_redirect_valid > fire increment.
  - dec_redirect_valid with flush_req low sets pc_r <= dec_redirect_pc. This applies in the same cycle as a fire and overrides the increment.
- flush_sh = flush_req, combinational, in any state. The ack is single-cycle because the commit stage drops flush_req one cycle after flush_sh.
  - On flush_sh: pc_r <= flush_pc, state <= RUN (a flush ends HOLD), pc_o_valid = 0 that cycle.
- RUN -> HOLD: if_hold_req & ~flush_req & ~fire. If a fire occurs in the same cycle, the transition happens the next cycle so that if_hold_pc reflects the incremented PC.
- HOLD:
  - pc_o_valid = 0, if_hold_rsp = 1, if_hold_pc = pc_r, frozen.
  - dec_redirect_valid is ignored.
- HOLD -> RUN: on flush_sh (normally the trap-vector flush from CSR), or when if_hold_req deasserts without a flush.
- if_hold_pc = pc_r in all states; it is meaningful only while if_hold_rsp = 1.
- Latency:
  - flush_req at cycle t → pc_o_valid with flush_pc at t+1.
  - if_hold_req at t with no fire → if_hold_rsp at t+1.
- BHT: 2^`BPU_IDX entries of 2-bit saturating counters.
  - On prdt_en: increment if prdt_res, decrement otherwise, saturating at 3 and 0.
  - Read is combinational from current state. A write to the same index in the same cycle is not bypassed; the new value is visible next cycle.
- Reset asserted mid-hold or mid-flush returns to RUN at RESET_PC with the BHT reinitialised.

Optional Feature:
LIEAT_BHT_EN
- Defined: BHT as above.
- Undefined: no counter storage; bht_rd_taken = 0 (static not-taken); prdt_* inputs ignored.

Decomposition:
- Shared package/defines: `XLEN, `BPU_IDX, RESET_PC default, state encodings PCGEN_RUN/PCGEN_HOLD, counter width and saturation constants.
- One sub-module, lieat_ifu_bht: counter array, update port, read port. Instantiated only under LIEAT_BHT_EN.
- Registers use lieat_general_dfflr.

Test Plan:
- Reset, pc_o_ready = 1 for 4 cycles → pc_o_addr 0x80000000, 0x80000004, 0x80000008, 0x8000000C; pc_o_ready = 0 holds 0x80000010.
- flush_req = 1, flush_pc = 0x80001000 while firing → flush_sh = 1 the same cycle, pc_o_valid = 0; next cycle pc_o_addr = 0x80001000.
- dec_redirect_valid with 0x80000200 together with flush_pc 0x80000300 → flush wins, next PC = 0x80000300.
- if_hold_req at pc_r = 0x80000040, ready low → if_hold_rsp = 1 next cycle, if_hold_pc = 0x80000040, pc_o_valid = 0. Then a flush to 0x80000100 → RUN, first fetch 0x80000100.
- pc_r = 0xFFFFFFFC, fire → wraps to 0x00000000.
- BHT: index 5, prdt_res = 1 ×3 → bht_rd_taken = 1, counter saturates at 3; prdt_res = 0 ×2 → taken = 0. With LIEAT_BHT_EN undefined → always 0.
